aging_priority_arbiter: RTL and testbench
=========================================

// Module: aging_priority_arbiter
// PURPOSE
//  N-way request arbiter with a registered output slot. Used wherever several
//  producers share one downstream issue port (cache/memory request paths).
//  Critical and starved (aged) requests win over normal ones; ties break round-robin.
//  Successor to the fixed-priority arbiter: adds aging, round-robin fairness and full-rate slot refill.
// PARAMETERS
//  NUM_REQUESTS                  3   number of request channels (>=2)
//  SINGLE_REQUEST_WIDTH_IN_BITS  64  payload width per channel
//  AGE_COUNTER_WIDTH             4   bits per per-channel wait counter
//  AGE_THRESHOLD                 8   wait cycles before promotion to urgent; 0 = aging disabled
//  INDEX_WIDTH  (localparam)         $clog2(NUM_REQUESTS)
// PORTS
//  clk_in                      in   1      clock, rising edge
//  reset_in                    in   1      asynchronous reset, active-high
//  request_packed_in           in   N*W    channel i payload at [i*W +: W]
//  request_valid_packed_in     in   N      channel i request present
//  request_critical_packed_in  in   N      channel i critical; ignored unless valid
//  issue_ack_out               out  N      one-hot: channel i captured into slot this cycle
//  request_out                 out  W      slot payload
//  request_valid_out           out  1      slot occupied
//  grant_index_out             out  IW     channel that filled the slot
//  issue_ack_in                in   1      downstream consumed slot this cycle
// BEHAVIOUR
//  Reset (async, immediate): request_out=0, request_valid_out=0, grant_index_out=0,
//   age counters=0, rr pointer=N-1 (first search starts at channel 0).
//  issue_ack_out is combinational; it is 0 while reset_in is high.
//  Slot load enable: load = ~request_valid_out | issue_ack_in.
//  urgent[i] = valid[i] & (critical[i] | (AGE_THRESHOLD!=0 & age[i]>=AGE_THRESHOLD)).
//  Candidate set = urgent if any urgent, else all valid channels.
//  Pick = first candidate at index (ptr+1), (ptr+2), ... mod N (wraps N-1 -> 0).
//  If load & candidate exists: issue_ack_out[pick]=1 in the same cycle. At the edge:
//   request_out<=payload[pick], request_valid_out<=1, grant_index_out<=pick, ptr<=pick.
//  If load & no candidate: issue_ack_out=0; request_valid_out<=0 when issue_ack_in, else it stays 0.
//  If ~load: slot, ptr and grant_index_out hold; issue_ack_out=0.
//  Consume + refill in the same cycle: valid_out stays 1 and the new payload
//   appears next cycle. This sustains 1 grant/cycle when issue_ack_in is held high.
//  issue_ack_in while slot empty: ignored; load is already 1.
//  Latency: request valid -> request_out valid = 1 cycle (slot empty).
//  Requester protocol: hold payload/valid/critical until issue_ack_out[i]. The
//   requester may advance to the next payload at the edge where the ack is high.
//  Age counter i: cleared when ~valid[i] or issue_ack_out[i]. Otherwise +1 per
//   cycle, saturating at all-ones. A channel that drops valid forfeits its age.
//  Aged urgency is equal to critical urgency. Order within the urgent set is round-robin only.
//  Reset mid-transfer: the slot contents are discarded; no ack is produced for them.
// TESTING  (N=3, W=64, AGE_THRESHOLD=8)
//  1. All 3 valid, none critical, issue_ack_in=1 constant -> grants 0,1,2,0,1,2,
//     one per cycle, no gaps in request_valid_out.
//  2. Slot full, issue_ack_in=0 for 5 cycles -> issue_ack_out=0, request_out stable;
//     ack on cycle 6 -> refill with next rr channel in the same edge.
//  3. All valid, ch2 critical, ptr=2 -> next grant is ch2 (not ch0); critical
//     cleared after ack -> rr resumes from ch0.
//  4. ch1 critical every grant, ch0 valid, ack every cycle -> ch0 reaches age 8 and
//     becomes urgent; it is granted within 2 slots of promotion; its age resets to 0.
//  5. Payload 64'h1 on ch0, single request -> request_out=64'h1 one cycle later,
//     grant_index_out=0; issue_ack_in with no valid -> request_valid_out=0.
//  6. reset_in pulsed while slot is full and ages are nonzero -> all outputs 0 immediately;
//     the first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/aging_priority_arbiter.sv
// N-way request arbiter feeding one registered issue slot.
// Critical or aged requests take precedence; ties resolve round-robin from the last grant.
module aging_priority_arbiter #(
  parameter int unsigned NUM_REQUESTS                 = 3,
  parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int unsigned AGE_COUNTER_WIDTH            = 4,
  parameter int unsigned AGE_THRESHOLD                = 8,
  localparam int unsigned INDEX_WIDTH                 = $clog2(NUM_REQUESTS)
) (
  input  logic                                                  clk_in,
  input  logic                                                  reset_in,
  input  logic [NUM_REQUESTS*SINGLE_REQUEST_WIDTH_IN_BITS-1:0]  request_packed_in,
  input  logic [NUM_REQUESTS-1:0]                               request_valid_packed_in,
  input  logic [NUM_REQUESTS-1:0]                               request_critical_packed_in,
  output logic [NUM_REQUESTS-1:0]                               issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]               request_out,
  output logic                                                  request_valid_out,
  output logic [INDEX_WIDTH-1:0]                                grant_index_out,
  input  logic                                                  issue_ack_in
);

  localparam int unsigned N  = NUM_REQUESTS;
  localparam int unsigned W  = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int unsigned AW = AGE_COUNTER_WIDTH;
  localparam int unsigned IW = INDEX_WIDTH;
  localparam logic [AW-1:0] AGE_MAX = '1;

  logic [W-1:0]  payload [N];
  logic [AW-1:0] age_q   [N];
  logic [IW-1:0] ptr_q;
  logic [N-1:0]  urgent;
  logic [N-1:0]  candidates;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick;
  logic          found;
  logic          load;
  int unsigned   idx;

  for (genvar g = 0; g < N; g++) begin : g_payload
    assign payload[g] = request_packed_in[g*W +: W];
  end

  // Aged urgency is indistinguishable from critical urgency.
  always_comb begin
    urgent = '0;
    for (int unsigned i = 0; i < N; i++) begin
      urgent[i] = request_valid_packed_in[i] &
                  (request_critical_packed_in[i] |
                   ((AGE_THRESHOLD != 0) && (32'(age_q[i]) >= AGE_THRESHOLD)));
    end
    candidates = (|urgent) ? urgent : request_valid_packed_in;
  end

  // Walk from the farthest offset down so the nearest candidate after ptr_q wins.
  always_comb begin
    found       = 1'b0;
    pick        = '0;
    idx         = 0;
    pick_onehot = '0;
    for (int unsigned k = N; k >= 1; k--) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (candidates[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
    if (found) pick_onehot = N'(1) << pick;
  end

  assign load          = ~request_valid_out | issue_ack_in;
  assign issue_ack_out = (load && !reset_in) ? pick_onehot : '0;

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      request_out       <= '0;
      request_valid_out <= 1'b0;
      grant_index_out   <= '0;
      ptr_q             <= IW'(N - 1);
    end else if (load) begin
      if (found) begin
        request_out       <= payload[pick];
        request_valid_out <= 1'b1;
        grant_index_out   <= pick;
        ptr_q             <= pick;
      end else begin
        request_valid_out <= 1'b0;
      end
    end
  end

  // A channel loses its accumulated age when it drops valid or is granted.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!request_valid_packed_in[i] || issue_ack_out[i]) age_q[i] <= '0;
        else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_aging_priority_arbiter.sv
// Directed and randomized checks of aging_priority_arbiter against an
// arithmetic reference model of ages, round-robin pointer and slot.
module tb_aging_priority_arbiter;

  localparam int N    = 3;
  localparam int W    = 64;
  localparam int TH   = 8;
  localparam int AMAX = 15;

  logic            clk_in = 1'b0;
  logic            reset_in;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    req_v;
  logic [N-1:0]    req_c;
  logic            ack_in;
  logic [N-1:0]    issue_ack_out;
  logic [W-1:0]    request_out;
  logic            request_valid_out;
  logic [1:0]      grant_index_out;

  aging_priority_arbiter #(
    .NUM_REQUESTS(N), .SINGLE_REQUEST_WIDTH_IN_BITS(W),
    .AGE_COUNTER_WIDTH(4), .AGE_THRESHOLD(TH)
  ) dut (
    .clk_in(clk_in),
    .reset_in(reset_in),
    .request_packed_in(req_data),
    .request_valid_packed_in(req_v),
    .request_critical_packed_in(req_c),
    .issue_ack_out(issue_ack_out),
    .request_out(request_out),
    .request_valid_out(request_valid_out),
    .grant_index_out(grant_index_out),
    .issue_ack_in(ack_in)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  int          m_age [N];
  int          m_ptr;
  logic        m_sv;
  logic [W-1:0] m_out;
  int          m_gi;
  logic [N-1:0] last_ack;
  logic [N-1:0] obs_ack;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_age[i] = 0;
    m_ptr = N - 1;
    m_sv  = 1'b0;
    m_out = '0;
    m_gi  = 0;
  endtask

  // Expected grant for the current inputs and model state; -1 when none.
  task automatic model_pick(output logic [N-1:0] oh, output int pick);
    logic [N-1:0] urg, cand;
    int ch;
    for (int i = 0; i < N; i++)
      urg[i] = req_v[i] && (req_c[i] || (TH != 0 && m_age[i] >= TH));
    cand = (urg != 0) ? urg : req_v;
    pick = -1;
    for (int k = 1; k <= N; k++) begin
      ch = (m_ptr + k) % N;
      if (pick < 0 && cand[ch]) pick = ch;
    end
    if (m_sv && !ack_in) pick = -1;
    oh = '0;
    if (pick >= 0) oh[pick] = 1'b1;
  endtask

  task automatic model_update(input logic [N-1:0] oh, input int pick);
    for (int i = 0; i < N; i++) begin
      if (!req_v[i] || oh[i]) m_age[i] = 0;
      else if (m_age[i] < AMAX) m_age[i] = m_age[i] + 1;
    end
    if (!m_sv || ack_in) begin
      if (pick >= 0) begin
        m_out = req_data[pick*W +: W];
        m_sv  = 1'b1;
        m_gi  = pick;
        m_ptr = pick;
      end else begin
        m_sv = 1'b0;
      end
    end
  endtask

  // One clock: check combinational ack, advance, check registered slot.
  task automatic step(input string tag);
    logic [N-1:0] oh;
    int pick;
    #1;
    model_pick(oh, pick);
    obs_ack = issue_ack_out;
    chk({tag, "_ack"}, 64'(issue_ack_out), 64'(oh));
    last_ack = oh;
    @(posedge clk_in);
    model_update(oh, pick);
    #1;
    chk({tag, "_out"}, request_out, m_out);
    chk({tag, "_vld"}, 64'(request_valid_out), 64'(m_sv));
    chk({tag, "_idx"}, 64'(grant_index_out), 64'(m_gi));
  endtask

  task automatic new_payload(input int i);
    req_data[i*W +: W] = {$urandom, $urandom};
  endtask

  task automatic refresh_acked();
    for (int i = 0; i < N; i++) if (last_ack[i]) new_payload(i);
  endtask

  task automatic rand_requesters();
    for (int i = 0; i < N; i++) begin
      if (!req_v[i] || last_ack[i]) begin
        req_v[i] = ($urandom_range(0, 3) != 0);
        req_c[i] = ($urandom_range(0, 4) == 0);
        new_payload(i);
      end
    end
  endtask

  initial begin
    reset_in = 1'b1;
    req_data = '0;
    req_v    = '0;
    req_c    = '0;
    ack_in   = 1'b0;
    last_ack = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_out", request_out, 64'h0);
    chk("rst_vld", 64'(request_valid_out), 64'h0);
    chk("rst_idx", 64'(grant_index_out), 64'h0);
    chk("rst_ack", 64'(issue_ack_out), 64'h0);
    reset_in = 1'b0;

    // Full-rate round robin with continuous consumption.
    req_v  = 3'b111;
    ack_in = 1'b1;
    for (int i = 0; i < N; i++) new_payload(i);
    for (int s = 0; s < 6; s++) begin
      step("t1");
      chk("t1_grant", 64'(grant_index_out), 64'(s % 3));
      chk("t1_nogap", 64'(request_valid_out), 64'h1);
      refresh_acked();
    end

    // Critical ch2 wins with ptr=2, then rr resumes at ch0.
    req_c = 3'b100;
    step("t3a");
    chk("t3_crit", 64'(grant_index_out), 64'h2);
    req_c = 3'b000;
    refresh_acked();
    step("t3b");
    chk("t3_resume", 64'(grant_index_out), 64'h0);
    refresh_acked();

    // Downstream stall for five cycles, then consume and refill.
    ack_in = 1'b0;
    for (int s = 0; s < 5; s++) begin
      step("t2h");
      chk("t2_noack", 64'(obs_ack), 64'h0);
    end
    ack_in = 1'b1;
    step("t2r");
    chk("t2_refill", 64'(grant_index_out), 64'h1);
    refresh_acked();

    // Aging promotes ch0 against a perpetually critical ch1.
    req_v = 3'b000;
    step("t4z");
    req_v = 3'b011;
    req_c = 3'b010;
    for (int k = 0; k < 12; k++) begin
      step("t4");
      chk("t4_grant", 64'(obs_ack), (k == 8) ? 64'h1 : 64'h2);
      refresh_acked();
    end
    req_c = 3'b000;

    // Single request latency, then empty-slot drain.
    req_v  = 3'b000;
    ack_in = 1'b1;
    step("t5z");
    chk("t5_empty", 64'(request_valid_out), 64'h0);
    req_v = 3'b001;
    req_data[0 +: W] = 64'h1;
    ack_in = 1'b0;
    step("t5");
    chk("t5_ack", 64'(obs_ack), 64'h1);
    chk("t5_data", request_out, 64'h1);
    chk("t5_idx", 64'(grant_index_out), 64'h0);
    req_v  = 3'b000;
    ack_in = 1'b1;
    step("t5d");
    chk("t5_drain", 64'(request_valid_out), 64'h0);

    // Asynchronous reset while the slot is full and ages are running.
    req_v  = 3'b111;
    ack_in = 1'b0;
    for (int i = 0; i < N; i++) new_payload(i);
    repeat (4) step("t6f");
    #2 reset_in = 1'b1;
    #1;
    chk("t6_out", request_out, 64'h0);
    chk("t6_vld", 64'(request_valid_out), 64'h0);
    chk("t6_idx", 64'(grant_index_out), 64'h0);
    chk("t6_ack", 64'(issue_ack_out), 64'h0);
    @(posedge clk_in);
    #1;
    chk("t6_hold", 64'(request_valid_out), 64'h0);
    chk("t6_ackh", 64'(issue_ack_out), 64'h0);
    reset_in = 1'b0;
    model_reset();
    last_ack = '0;
    req_v = 3'b110;
    step("t6p");
    chk("t6_first", 64'(grant_index_out), 64'h1);

    // Randomized traffic against the reference model.
    for (int s = 0; s < 400; s++) begin
      ack_in = ($urandom_range(0, 1) != 0);
      rand_requesters();
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
